seq_det_ctrl: RTL

//  Stream controller for the serial sequence detector (seq_detector).
//  - Accepts parallel words over a valid/ready handshake.
//  - Serialises each word MSB-first onto the detector's serial input.
//  - Counts detector hits that belong to that word's bit window.
//  - Reports a per-word hit count with a one-cycle done pulse.

---
 rtl/seq_det_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl -- stream controller for the serial sequence detector.
//
// Takes one W-bit word per valid/ready handshake, shifts it out MSB-first on
// det_bit (qualified by det_en), counts detector hits that fall inside the
// word's bit window (shifted by the detector latency) and reports the count
// with a one-cycle done pulse.
//
// Optional feature macro: SEQ_CTRL_TOTAL_EN
//   defined   -> total_hits keeps a saturating running sum of every hit_cnt
//   undefined -> total_hits is tied to zero
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active low
//   in_valid   in   1      in_data valid
//   in_ready   out  1      controller can accept a word (IDLE only)
//   in_data    in   W      word to scan
//   det_bit    out  1      serial bit to the detector
//   det_en     out  1      det_bit carries a word bit
//   det_hit    in   1      detector output
//   busy       out  1      high in SHIFT/DONE
//   done       out  1      one-cycle pulse, hit_cnt valid
//   hit_cnt    out  CNT_W  hits of the last completed word
//   total_hits out  TOT_W  saturating running total of hits
module seq_det_ctrl #(
    parameter int W       = 8,
    parameter int CNT_W   = 4,
    parameter int DET_LAT = 1,
    parameter int TOT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             det_bit,
    output logic             det_en,
    input  logic             det_hit,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [TOT_W-1:0] total_hits
);

    // SHIFT runs cyc = 0 .. W+DET_LAT-1
    localparam int CYC_W = (W + DET_LAT > 2) ? $clog2(W + DET_LAT) : 1;

    localparam logic [CYC_W-1:0] LAT_C  = CYC_W'(DET_LAT);
    localparam logic [CYC_W-1:0] LAST_C = CYC_W'(W + DET_LAT - 1);
    localparam logic [CYC_W-1:0] WM1_C  = CYC_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [W-1:0]     sreg;
    logic [CYC_W-1:0] cyc;
    logic [CNT_W-1:0] acc;

    logic             in_win;
    logic             sample;
    logic             last;
    logic [CNT_W-1:0] acc_next;

    // Hits are only credited once the first bit has had DET_LAT cycles to
    // travel through the detector; the drain cycles cover the tail bits.
    always_comb begin
        in_win   = (cyc >= LAT_C);
        sample   = (state == SHIFT) && in_win && det_hit;
        last     = (state == SHIFT) && (cyc == LAST_C);
        acc_next = acc;
        if (sample && (acc != CNT_MAX))
            acc_next = acc + 1'b1;
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sreg    <= '0;
            cyc     <= '0;
            acc     <= '0;
            hit_cnt <= '0;
            det_bit <= 1'b0;
            det_en  <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (in_valid) begin
                        // Present the MSB in the very first SHIFT cycle.
                        sreg    <= in_data;
                        cyc     <= '0;
                        acc     <= '0;
                        det_bit <= in_data[W-1];
                        det_en  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg <= sreg << 1;
                    cyc  <= cyc + 1'b1;
                    acc  <= acc_next;
                    // Next cycle still carries a word bit only if cyc+1 < W.
                    if (cyc < WM1_C) begin
                        det_bit <= sreg[W-2];
                        det_en  <= 1'b1;
                    end else begin
                        det_bit <= 1'b0;
                        det_en  <= 1'b0;
                    end
                    if (last) begin
                        hit_cnt <= acc_next;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    det_bit <= 1'b0;
                    det_en  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_CTRL_TOTAL_EN
    // One spare bit catches the carry so the total pins at all-ones.
    logic [TOT_W:0] tot_sum;

    always_comb begin
        tot_sum = {1'b0, total_hits} + (TOT_W + 1)'(acc_next);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_hits <= '0;
        end else if (last) begin
            total_hits <= tot_sum[TOT_W] ? {TOT_W{1'b1}} : tot_sum[TOT_W-1:0];
        end
    end
`else
    assign total_hits = '0;
`endif

endmodule
